clock_control: RTL and testbench
================================

// Module: clock_control
// PURPOSE
// - Sits directly upstream of datapath and gates the CPU clock.
// - Turns the raw panel controls (step button, step/run switch, instr/cycle switch, breakpoint enable)
//   and CPU status (PC, end-of-instruction, halt) into a single registered clock enable.
// - Every datapath register advances only on i_oszClk edges where o_cpuClkEn=1.
// PARAMETERS
// - DEBOUNCE_CYCLES  100000  consecutive stable i_oszClk cycles before the step button is accepted (1 ms at 100 MHz)
// - RUN_DIV          1        in RUN, one enable pulse every RUN_DIV cycles (1 = every cycle); must be >=1
// - ADDR_W           16       PC / breakpoint address width
// PORTS
// - i_oszClk              in   1       system clock; the only clock
// - i_reset               in   1       asynchronous, active-high reset
// - i_btnStep             in   1       raw step button, 1 = pressed; asynchronous, bouncing
// - i_swStepNRun          in   1       1 = step mode, 0 = run; asynchronous
// - i_swInstrNCycle       in   1       1 = step one instruction, 0 = step one cycle; asynchronous
// - i_swEnableBreakpoint  in   1       1 = breakpoint armed in RUN; asynchronous
// - i_breakpointAddress   in   ADDR_W  breakpoint address
// - i_pc                  in   ADDR_W  CPU program counter, valid when i_instrDone=1
// - i_instrDone           in   1       CPU in last microstep of an instruction
// - i_halt                in   1       CPU executing HLT
// - o_cpuClkEn            out  1       registered CPU clock enable
// - o_state               out  3       current FSM state (ctrl_state_t)
// - o_cycleCount          out  32      enabled-cycle counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE, o_cpuClkEn=0, o_cycleCount=0, sync/debounce regs=0, resume flag=0.
//   Reset mid-operation aborts any step/run immediately.
// - Inputs: all switches and the button pass through 2-FF synchronisers.
//   The debounced button updates only after DEBOUNCE_CYCLES equal samples.
//   "press" = 1-cycle pulse on the debounced 0->1 edge.
//   Press-to-enable latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
// - "Boundary" = a cycle with o_cpuClkEn=1 and i_instrDone=1.
//   "bp hit" = boundary, sync'd breakpoint enable=1, i_pc==i_breakpointAddress, resume flag=0.
// - IDLE: enable=0.
//     step mode, press, cycle sel -> one enable pulse (1 cycle), stay IDLE.
//     step mode, press, instr sel -> STEP_INSTR.
//     run mode -> RUN (no press needed).
// - STEP_INSTR: enable every cycle; breakpoint ignored; at boundary -> IDLE.
//     Press while here is ignored.
// - RUN: enable every RUN_DIV cycles (prescaler wraps RUN_DIV-1 -> 0; pulse on wrap).
//     At boundary: bp hit -> BREAK; else step mode selected -> IDLE; else stay.
//     Resume flag clears at the first boundary.
//     Mode switch never stops mid-instruction.
// - BREAK: enable=0.
//     press in run mode -> set resume flag, RUN (same address is not re-hit).
//     step mode -> IDLE.
// - HALTED: entered from any state on a cycle with o_cpuClkEn=1 and i_halt=1; priority over bp and mode.
//     enable=0 permanently; only i_reset exits.
// - o_cpuClkEn is registered: decisions made in cycle n drive the enable in cycle n+1.
//   It is never asserted in IDLE (except the single-cycle pulse), BREAK or HALTED.
// CONFIGURATION
// - CLOCK_CONTROL_CYCLE_COUNT_EN defined:
//     o_cycleCount increments on every cycle with o_cpuClkEn=1, wraps 2^32-1 -> 0, clears on reset.
// - Not defined: o_cycleCount tied to 32'd0, no counter logic.
// STRUCTURE
// - Package edic_ctrl_pkg:
//     ctrl_state_t enum {IDLE=0, STEP_INSTR=1, RUN=2, BREAK=3, HALTED=4} (3 bits);
//     localparam CYCLE_CNT_W=32.
// - Sub-module button_debouncer (#DEBOUNCE_CYCLES): sync + stable counter + edge pulse; one instance for i_btnStep.
// - Switch synchronisers inline; FSM + prescaler in this module.
// TESTING (bench: DEBOUNCE_CYCLES=4, RUN_DIV=1 unless stated)
// - Reset with step mode, i_btnStep held 1 for 3 cycles then bouncing -> no enable pulse.
//   Clean press for 8 cycles, cycle sel -> exactly one o_cpuClkEn pulse, 7 cycles after press edge.
// - Step mode, instr sel, instrDone on 4th enabled cycle -> exactly 4 enables, state back to IDLE.
// - Run mode, bp enabled, bp=16'h00ff, instrDone with pc=16'h00ff -> o_state=BREAK on the next cycle, enable 0.
//   Press -> RUN resumes and passes pc=16'h00ff once without stopping.
// - Run mode, RUN_DIV=3 -> enable pattern 0,0,1 repeating.
//   Flip to step mode mid-instruction -> enables continue until the boundary, then IDLE.
// - i_halt=1 on an enabled cycle -> HALTED, enable stays 0 through presses and mode flips.
//   i_reset mid-RUN -> IDLE, enable 0 in the same cycle.
// - With CLOCK_CONTROL_CYCLE_COUNT_EN, 10 run cycles -> o_cycleCount=10.
//   Preload 32'hffffffff, one more enable -> 0.
//   Without the macro -> o_cycleCount constant 0.

Source files
------------

// File: rtl/edic_ctrl_pkg.sv
// Shared types for the panel clock controller: FSM state encoding and counter width.
package edic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STEP_INSTR = 3'd1,
    RUN        = 3'd2,
    BREAK      = 3'd3,
    HALTED     = 3'd4
  } ctrl_state_t;

  localparam int unsigned CYCLE_CNT_W = 32;

endpackage

// File: rtl/clock_control_debouncer.sv
// Step-button conditioner: 2-FF synchroniser, stable-sample counter and a one-cycle
// registered pulse on the accepted 0->1 transition.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Count consecutive samples that disagree with the accepted level; any agreement restarts.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_btn};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/clock_control.sv
// CPU clock-enable generator for the front panel (step / run / breakpoint / halt).
// Optional enabled-cycle counter: define CLOCK_CONTROL_CYCLE_COUNT_EN.
module clock_control
  import edic_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned RUN_DIV         = 1,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic                   i_oszClk,
  input  logic                   i_reset,
  input  logic                   i_btnStep,
  input  logic                   i_swStepNRun,
  input  logic                   i_swInstrNCycle,
  input  logic                   i_swEnableBreakpoint,
  input  logic [ADDR_W-1:0]      i_breakpointAddress,
  input  logic [ADDR_W-1:0]      i_pc,
  input  logic                   i_instrDone,
  input  logic                   i_halt,
  output logic                   o_cpuClkEn,
  output logic [2:0]             o_state,
  output logic [CYCLE_CNT_W-1:0] o_cycleCount
);

  localparam int unsigned PRE_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RUN_DIV - 1);

  ctrl_state_t      state_q, state_d;
  logic             en_q, en_d;
  logic             resume_q, resume_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [2:0]       sw1_q, sw2_q;
  logic             press;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_step (
    .i_clk   (i_oszClk),
    .i_reset (i_reset),
    .i_btn   (i_btnStep),
    .o_press (press)
  );

  logic step_mode, instr_sel, bp_en;
  assign step_mode = sw2_q[0];
  assign instr_sel = sw2_q[1];
  assign bp_en     = sw2_q[2];

  logic boundary, halt_ev, bp_hit;
  assign boundary = en_q & i_instrDone;
  assign halt_ev  = en_q & i_halt;
  assign bp_hit   = boundary & bp_en & (i_pc == i_breakpointAddress) & ~resume_q;

  // Next-state and next-enable; halt outranks breakpoint and mode changes.
  always_comb begin
    state_d  = state_q;
    en_d     = 1'b0;
    resume_d = resume_q;
    presc_d  = presc_q;
    if (halt_ev) begin
      state_d = HALTED;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!step_mode) begin
            state_d = RUN;
            presc_d = '0;
          end else if (press) begin
            en_d = 1'b1;
            if (instr_sel) state_d = STEP_INSTR;
          end
        end
        STEP_INSTR: begin
          if (boundary) state_d = IDLE;
          else          en_d    = 1'b1;
        end
        RUN: begin
          if (boundary) resume_d = 1'b0;
          if (bp_hit) begin
            state_d = BREAK;
          end else if (boundary && step_mode) begin
            state_d = IDLE;
          end else if (presc_q == PRE_MAX) begin
            presc_d = '0;
            en_d    = 1'b1;
          end else begin
            presc_d = presc_q + PRE_W'(1);
          end
        end
        BREAK: begin
          if (!step_mode && press) begin
            state_d  = RUN;
            resume_d = 1'b1;
            presc_d  = '0;
          end else if (step_mode) begin
            state_d = IDLE;
          end
        end
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      resume_q <= 1'b0;
      presc_q  <= '0;
      sw1_q    <= '0;
      sw2_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      resume_q <= resume_d;
      presc_q  <= presc_d;
      sw1_q    <= {i_swEnableBreakpoint, i_swInstrNCycle, i_swStepNRun};
      sw2_q    <= sw1_q;
    end
  end

  assign o_cpuClkEn = en_q;
  assign o_state    = state_q;

`ifdef CLOCK_CONTROL_CYCLE_COUNT_EN
  logic [CYCLE_CNT_W-1:0] cyc_q;

  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset)   cyc_q <= '0;
    else if (en_q) cyc_q <= cyc_q + CYCLE_CNT_W'(1);
  end

  assign o_cycleCount = cyc_q;
`else
  assign o_cycleCount = '0;
`endif

endmodule

// File: tb/tb_clock_control.sv
// Scoreboard bench for clock_control (DEBOUNCE_CYCLES=4; RUN_DIV=1 and a RUN_DIV=3 instance).
module tb_clock_control;
  import edic_ctrl_pkg::*;

  logic        clk, rst, rst3;
  logic        btn, step, instr, bpen, idone, halt;
  logic [15:0] bpa, pc;
  logic        en, en3;
  logic [2:0]  st, st3;
  logic [31:0] cnt, cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          id;
    int          idx;
    logic        en;
    ctrl_state_t st;
    logic        use3;
  } exp_t;

  exp_t sb_q[$];

  clock_control #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1), .ADDR_W(16)) dut (
    .i_oszClk(clk), .i_reset(rst), .i_btnStep(btn), .i_swStepNRun(step),
    .i_swInstrNCycle(instr), .i_swEnableBreakpoint(bpen), .i_breakpointAddress(bpa),
    .i_pc(pc), .i_instrDone(idone), .i_halt(halt),
    .o_cpuClkEn(en), .o_state(st), .o_cycleCount(cnt)
  );

  clock_control #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3), .ADDR_W(16)) dut3 (
    .i_oszClk(clk), .i_reset(rst3), .i_btnStep(btn), .i_swStepNRun(step),
    .i_swInstrNCycle(instr), .i_swEnableBreakpoint(bpen), .i_breakpointAddress(bpa),
    .i_pc(pc), .i_instrDone(idone), .i_halt(halt),
    .o_cpuClkEn(en3), .o_state(st3), .o_cycleCount(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input int idx, input logic e, input ctrl_state_t s,
                      input logic use3);
    exp_t x;
    x.id = id; x.idx = idx; x.en = e; x.st = s; x.use3 = use3;
    sb_q.push_back(x);
  endtask

  // Each expectation is pushed at a falling edge and compared just after the next rising edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb_q.size() != 0) begin
      x = sb_q.pop_front();
      check($sformatf("t%0d_c%0d_en", x.id, x.idx), 32'(x.use3 ? en3 : en), 32'(x.en));
      check($sformatf("t%0d_c%0d_state", x.id, x.idx), 32'(x.use3 ? st3 : st), 32'(x.st));
    end
  end

  initial begin
    rst = 1'b1; rst3 = 1'b1; btn = 1'b0; step = 1'b1; instr = 1'b0; bpen = 1'b0;
    bpa = 16'h00ff; pc = 16'h0000; idone = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(st), 32'(IDLE));
    check("rst_en", 32'(en), 32'd0);
    check("rst_cnt", cnt, 32'd0);

    // t0: synchronisers start at 0 (= run), so one RUN enable occurs until the first boundary
    @(negedge clk); rst = 1'b0; idone = 1'b1; push(0, 0, 1'b0, RUN, 1'b0);
    @(negedge clk); push(0, 1, 1'b1, RUN, 1'b0);
    @(negedge clk); push(0, 2, 1'b0, IDLE, 1'b0);
    @(negedge clk); idone = 1'b0; push(0, 3, 1'b0, IDLE, 1'b0);

    // t1: short press then bouncing never qualifies
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      btn = (i < 3) ? 1'b1 : ((i < 15) ? ((i % 2) == 0) : 1'b0);
      push(1, i, 1'b0, IDLE, 1'b0);
    end

    // t2: clean press, cycle step -> single pulse 7 cycles after the press edge
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn = (i < 8);
      push(2, i, (i == 6), IDLE, 1'b0);
    end

    // t3: instruction step, instrDone on the 4th enabled cycle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      instr = 1'b1; btn = (i < 8); idone = (i == 10);
      push(3, i, (i >= 6 && i <= 9), (i >= 6 && i <= 9) ? STEP_INSTR : IDLE, 1'b0);
    end

    // t4: run into breakpoint at 16'h00ff
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      step = 1'b0; instr = 1'b0; bpen = 1'b1; btn = 1'b0;
      idone = (i == 5); pc = (i == 5) ? 16'h00ff : 16'h0010;
      push(4, i, (i == 3 || i == 4), (i < 2) ? IDLE : ((i < 5) ? RUN : BREAK), 1'b0);
    end

    // t5: resume passes 16'h00ff once, re-hits it, then step mode returns to IDLE
    for (int j = 0; j < 18; j++) begin
      ctrl_state_t s;
      @(negedge clk);
      btn = (j < 8); step = (j >= 12); idone = (j == 8 || j == 10);
      pc = idone ? 16'h00ff : 16'h0010;
      if (j < 6 || (j >= 10 && j < 14)) s = BREAK;
      else if (j < 10)                  s = RUN;
      else                              s = IDLE;
      push(5, j, (j >= 7 && j <= 9), s, 1'b0);
    end

    // t6: RUN_DIV=3 pattern, then a mid-instruction switch to step mode
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst3 = 1'b0; bpen = 1'b0; btn = 1'b0; idone = (i == 13); pc = 16'h0010;
      step = (i >= 7);
      push(6, i, (i >= 3 && (i % 3) == 0 && i <= 12), (i >= 13) ? IDLE : RUN, 1'b1);
    end
    @(negedge clk);
`ifdef CLOCK_CONTROL_CYCLE_COUNT_EN
    check("div3_cnt", cnt3, 32'd4);
`else
    check("div3_cnt", cnt3, 32'd0);
`endif

    // t7: halt on an enabled cycle is sticky through presses and mode flips
    for (int k = 0; k < 31; k++) begin
      ctrl_state_t s;
      @(negedge clk);
      step = (k < 8) ? 1'b0 : ((k < 20) ? 1'b1 : 1'b0);
      halt = (k == 4); btn = (k >= 6 && k < 14); idone = 1'b0;
      if (k < 2)       s = IDLE;
      else if (k < 4)  s = RUN;
      else             s = HALTED;
      push(7, k, (k == 3), s, 1'b0);
    end

    // t8: reset aborts RUN asynchronously
    @(negedge clk); rst = 1'b1;
    for (int m = 0; m < 6; m++) begin
      @(negedge clk);
      rst = 1'b0;
      push(8, m, (m >= 1), RUN, 1'b0);
    end
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_run_en", 32'(en), 32'd0);
    check("rst_run_state", 32'(st), 32'(IDLE));

    // t9: enabled-cycle counter
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
`ifdef CLOCK_CONTROL_CYCLE_COUNT_EN
    check("cnt_10", cnt, 32'd10);
    @(negedge clk);
    force dut.cyc_q = 32'hffffffff;
    #1;
    release dut.cyc_q;
    @(posedge clk);
    #1;
    check("cnt_wrap", cnt, 32'd0);
`else
    check("cnt_off", cnt, 32'd0);
`endif

    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
